// File: rtl/nes_pkg.sv
// Shared types and button bit positions for the NES two-pad poll scheduler.
package nes_pkg;

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} nes_state_t;

    typedef logic [7:0] nes_buttons_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_capture.sv
// Per-pad capture: optional DATA synchronizer (NES_DATA_SYNC_EN), serial shift register,
// active-low decode and press-edge detection.
module nes_pad_capture
    import nes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         data,
    input  logic         sample,
    input  logic [2:0]   idx,
    input  logic         commit,
    output nes_buttons_t buttons,
    output nes_buttons_t pressed
);

    logic         data_s;
    nes_buttons_t shift_q;

    // NOTE: state is written with non-blocking assignments so every register sees the pre-edge values.
    // NOTE: the shift register is reset as well, so an aborted poll cannot leak stale bits into a later one.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '1;
        end else if (sample) begin
            shift_q[idx] <= data_s;
        end
    end

`ifdef NES_DATA_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], data};
        end
    end

    assign data_s = sync_q[1];
`else
    assign data_s = data;
`endif

    // Pressed compares against the previously published state before it is overwritten.
    always_ff @(posedge clock) begin
        if (reset) begin
            buttons <= '0;
            pressed <= '0;
        end else if (commit) begin
            buttons <= ~shift_q;
            pressed <= ~shift_q & ~buttons;
        end else begin
            pressed <= '0;
        end
    end

endmodule

// File: rtl/nes_poll_scheduler.sv
// Two-pad NES controller poller: periodic/on-demand poll scheduling and LATCH/PULSE sequencing.
// Define NES_DATA_SYNC_EN to add a 2-flop synchronizer on each DATA input.
module nes_poll_scheduler
    import nes_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned POLL_HZ         = 60,
    parameter int unsigned LATCH_CYCLES    = 600,
    parameter int unsigned HALF_BIT_CYCLES = 300
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         poll_req,
    output logic         poll_busy,
    output logic         nes_latch,
    output logic         nes_pulse,
    input  logic [1:0]   nes_data,
    output nes_buttons_t buttons_p0,
    output nes_buttons_t buttons_p1,
    output logic         valid,
    output nes_buttons_t pressed_p0,
    output nes_buttons_t pressed_p1
);

    localparam int unsigned POLL_DIV = CLK_HZ / POLL_HZ;
    localparam int unsigned TICK_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned PH_MAX   = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
    localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(POLL_DIV - 1);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_BIT_CYCLES - 1);

    nes_state_t        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [2:0]        idx_q, idx_d;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick, poll_event;
    logic              pending_q, pending_d;
    logic              sample, commit;

    assign tick       = (tick_cnt == TICK_LAST);
    assign poll_event = poll_req | tick;
    assign poll_busy  = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            tick_cnt  <= '0;
            valid     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            tick_cnt  <= tick ? '0 : tick_cnt + TICK_W'(1);
            valid     <= commit;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + PH_W'(1);
        idx_d     = idx_q;
        pending_d = pending_q | poll_event;
        nes_latch = 1'b0;
        nes_pulse = 1'b1;
        sample    = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (pending_q | poll_event) begin
                    state_d   = LATCH;
                    // A queued poll is consumed; a fresh event in the same cycle queues the next one.
                    pending_d = pending_q & poll_event;
                end
            end
            LATCH: begin
                nes_latch = 1'b1;
                if (phase_q == LATCH_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                    idx_d   = '0;
                end
            end
            LOW: begin
                nes_pulse = 1'b0;
                if (phase_q == HALF_LAST) begin
                    sample  = 1'b1;
                    phase_d = '0;
                    state_d = (idx_q == 3'd7) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (phase_q == HALF_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                    idx_d   = idx_q + 3'd1;
                end
            end
            DONE: begin
                // PULSE stays low here so the return to idle-high is not an 8th shift inside the poll.
                nes_pulse = 1'b0;
                commit    = 1'b1;
                phase_d   = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    nes_pad_capture u_pad0 (
        .clock   (clock),
        .reset   (reset),
        .data    (nes_data[0]),
        .sample  (sample),
        .idx     (idx_q),
        .commit  (commit),
        .buttons (buttons_p0),
        .pressed (pressed_p0)
    );

    nes_pad_capture u_pad1 (
        .clock   (clock),
        .reset   (reset),
        .data    (nes_data[1]),
        .sample  (sample),
        .idx     (idx_q),
        .commit  (commit),
        .buttons (buttons_p1),
        .pressed (pressed_p1)
    );

endmodule

// File: doc/nes_poll_scheduler.md
Name: nes_poll_scheduler

Overview:
- Sequences the NES controller serial protocol for two pads that share one LATCH line and one PULSE line, each with its own DATA line.
- Generates periodic polls and on-demand polls, then drives the latch and shift pulses.
- Captures both pads' 8-bit reports at once, decodes them to active-high buttons and publishes them atomically with a valid strobe and press events.
- Sits between the pad connector pins and game logic; replaces ad-hoc per-pad polling.

Parameters:
- CLK_HZ, 50000000, frequency of clock in Hz.
- POLL_HZ, 60, rate of automatic polls; POLL_DIV = CLK_HZ/POLL_HZ cycles, integer divide.
- LATCH_CYCLES, 600, cycles LATCH is held high (12 us at 50 MHz); must be >= 1.
- HALF_BIT_CYCLES, 300, cycles per PULSE half-period (6 us at 50 MHz); must be >= 1.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- poll_req  in  1  single-cycle request for an immediate poll.
- poll_busy  out  1  high while a poll sequence is in progress.
- nes_latch  out  1  shared LATCH to both pads.
- nes_pulse  out  1  shared PULSE (shift clock) to both pads; idles high.
- nes_data  in  2  DATA from pad 0 in bit 0 and pad 1 in bit 1; active-low (0 = pressed).
- buttons_p0  out  8  pad 0 state, active-high; bit order A,B,Select,Start,Up,Down,Left,Right (bits 0..7).
- buttons_p1  out  8  pad 1 state, same order.
- valid  out  1  one-cycle strobe when buttons_p0/p1 update.
- pressed_p0  out  8  one-cycle rising-edge events, aligned with valid.
- pressed_p1  out  8  same, pad 1.

Behaviour:
- Reset:
  - state=IDLE; nes_latch=0; nes_pulse=1; poll_busy=0; valid=0.
  - buttons_p0/p1=0; pressed_p0/p1=0.
  - pending=0; tick counter=0; bit index=0.
- Tick counter counts 0..POLL_DIV-1. At POLL_DIV-1 it wraps and sets pending. It free-runs independent of state.
- poll_req=1 sets pending. A tick and a req in the same cycle give one pending. Pending coalesces to at most one queued poll.
- IDLE:
  - If pending, go to LATCH next cycle and clear pending.
  - A req or tick arriving in that same cycle re-sets pending, which queues one follow-up poll.
- LATCH: nes_latch=1, nes_pulse=1 for exactly LATCH_CYCLES cycles, then go to LOW with bit index=0.
- LOW:
  - nes_latch=0, nes_pulse=0 for HALF_BIT_CYCLES cycles.
  - On the last cycle, shift[idx] <= nes_data for both pads.
  - If idx==7, go to DONE; else go to HIGH.
- HIGH: nes_pulse=1 for HALF_BIT_CYCLES cycles; idx increments on exit; then go to LOW.
- Pulse count: 7 rising PULSE edges per poll. No 8th pulse is emitted.
- DONE (1 cycle):
  - buttons_pN <= ~shiftN.
  - pressedN <= ~shiftN & ~buttons_pN_old.
  - valid=1 registered; visible on the cycle after DONE.
  - Next state is IDLE.
- pressed_pN is 0 in every cycle except the valid cycle.
- poll_busy=1 from LATCH entry through DONE inclusive. poll_req during busy only sets pending; it never restarts the sequence.
- Poll duration = LATCH_CYCLES + 15*HALF_BIT_CYCLES + 1 cycles (5101 at defaults).
- Reset mid-poll aborts the poll. Outputs return to reset values on the next cycle, and no valid is issued.
- An unplugged pad (DATA pulled up) reads all 1s, which decodes to buttons=0. No error signalling.
- If POLL_DIV is shorter than the poll duration, polls run back to back with one IDLE cycle between them.

Optional Feature:
- Macro: NES_DATA_SYNC_EN.
- Defined: nes_data passes through a 2-flop synchronizer per bit before sampling. The sample point is unchanged, and the data seen is 2 cycles older; HALF_BIT_CYCLES must be >= 3.
- Undefined: nes_data is sampled directly. Only valid when the pad DATA is already synchronous.

Decomposition:
- Package nes_pkg:
  - state enum {IDLE, LATCH, LOW, HIGH, DONE}.
  - typedef nes_buttons_t = logic [7:0].
  - Button index constants BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7.
- Sub-module nes_pad_capture, one instance per pad. It contains the optional synchronizer, the shift register (written at the sample strobe with idx), and the decode/edge-detect/output registers (updated at the commit strobe).
- The scheduler keeps the FSM, cycle counters, tick counter and pending flag.

Test Plan (CLK_HZ=1000, POLL_HZ=10, LATCH_CYCLES=4, HALF_BIT_CYCLES=2 → POLL_DIV=100, duration 35):
- Reset release, idle data=2'b11: first LATCH at cycle 100, high 4 cycles; 7 PULSE rising edges; valid once; buttons_p0=buttons_p1=0x00; poll_busy high 35 cycles.
- Pad 0 drives A and Start low (bits 0, 3), pad 1 drives Right low (bit 7): buttons_p0=0x09, buttons_p1=0x80; pressed_p0=0x09 and pressed_p1=0x80 on the valid cycle; next poll with the same data gives pressed=0x00.
- Pad 0 holds 0x01, then releases A and presses B: buttons_p0=0x02, pressed_p0=0x02.
- poll_req at cycle 10 while idle: LATCH at cycle 11. A second poll_req at cycle 20 (busy) starts exactly one follow-up LATCH on the cycle after IDLE is re-entered. Three reqs during busy still give one follow-up.
- reset asserted at the 3rd LOW phase: next cycle nes_latch=0, nes_pulse=1, busy=0, buttons=0, no valid; the next poll starts 100 cycles after reset release.
- With NES_DATA_SYNC_EN, HALF_BIT_CYCLES=3, pattern 0xA5 active-low on pad 1: buttons_p1=0x5A.
